// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared state enum, default widths and saturating helpers for the bbox detector
package bbox_pkg;

  localparam int unsigned DEF_H_CNT_W    = 12;
  localparam int unsigned DEF_V_CNT_W    = 12;
  localparam int unsigned DEF_MIN_PIXELS = 64;
  localparam int unsigned DEF_PIX_CNT_W  = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2
  } bbox_state_e;

  // All-ones value of a w-bit counter, carried in a 32-bit container.
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v == sat_max(w)) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/binary_stream_coord_counter.sv
// rtl/binary_stream_coord_counter.sv - x/y coordinates and line/frame edge events of a binary mask stream
module binary_stream_coord_counter
  import bbox_pkg::*;
#(
  parameter int unsigned H_CNT_W = DEF_H_CNT_W,
  parameter int unsigned V_CNT_W = DEF_V_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               href,
  input  logic               clken,
  output logic [H_CNT_W-1:0] x,
  output logic [V_CNT_W-1:0] y,
  output logic               pixel_valid,
  output logic               line_end,
  output logic               frame_start,
  output logic               frame_end
);

  logic vsync_d;
  logic href_d;
  logic seen_low;
  logic line_has_pix;

  assign pixel_valid = vsync & href & clken;
  assign line_end    = href_d & ~href;
  // A rising edge needs a genuinely observed low sample, so a frame already
  // running when reset releases is never mistaken for a new one.
  assign frame_start = seen_low & ~vsync_d & vsync;
  assign frame_end   = vsync_d & ~vsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      href_d       <= 1'b0;
      seen_low     <= 1'b0;
      line_has_pix <= 1'b0;
      x            <= '0;
      y            <= '0;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
      if (!vsync) seen_low <= 1'b1;
      if (frame_start) begin
        x            <= '0;
        y            <= '0;
        line_has_pix <= 1'b0;
      end else if (line_end) begin
        x            <= '0;
        line_has_pix <= 1'b0;
        if (line_has_pix) y <= V_CNT_W'(sat_inc(32'(y), V_CNT_W));
      end else if (pixel_valid) begin
        x            <= H_CNT_W'(sat_inc(32'(x), H_CNT_W));
        line_has_pix <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/binary_bbox_detector.sv
// rtl/binary_bbox_detector.sv - per-frame foreground bounding box; BBOX_PIX_CNT_EN adds bbox_pix_cnt output
module binary_bbox_detector
  import bbox_pkg::*;
#(
  parameter int unsigned H_CNT_W    = DEF_H_CNT_W,
  parameter int unsigned V_CNT_W    = DEF_V_CNT_W,
  parameter int unsigned MIN_PIXELS = DEF_MIN_PIXELS,
  parameter int unsigned PIX_CNT_W  = DEF_PIX_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pre_frame_vsync,
  input  logic                 pre_frame_href,
  input  logic                 pre_frame_clken,
  input  logic                 pre_img_Bit,
  output logic                 bbox_valid,
  output logic                 bbox_found,
  output logic [H_CNT_W-1:0]   bbox_x_min,
  output logic [H_CNT_W-1:0]   bbox_x_max,
  output logic [V_CNT_W-1:0]   bbox_y_min,
  output logic [V_CNT_W-1:0]   bbox_y_max
`ifdef BBOX_PIX_CNT_EN
  ,
  output logic [PIX_CNT_W-1:0] bbox_pix_cnt
`endif
);

  logic [H_CNT_W-1:0]   x;
  logic [V_CNT_W-1:0]   y;
  logic                 pixel_valid;
  logic                 unused_line_end;
  logic                 frame_start;
  logic                 frame_end;

  bbox_state_e          state_q, state_d;
  logic                 clear_trk;
  logic                 report;
  logic                 fg;
  logic                 found;
  logic [H_CNT_W-1:0]   x_min, x_max;
  logic [V_CNT_W-1:0]   y_min, y_max;
  logic [PIX_CNT_W-1:0] pix_cnt;

  binary_stream_coord_counter #(
    .H_CNT_W (H_CNT_W),
    .V_CNT_W (V_CNT_W)
  ) u_coord (
    .clk         (clk),
    .rst         (rst),
    .vsync       (pre_frame_vsync),
    .href        (pre_frame_href),
    .clken       (pre_frame_clken),
    .x           (x),
    .y           (y),
    .pixel_valid (pixel_valid),
    .line_end    (unused_line_end),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clear_trk = 1'b0;
    report    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = ACTIVE;
          clear_trk = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_end) state_d = REPORT;
      end
      REPORT: begin
        report = 1'b1;
        // A new frame may open in the same cycle the previous one reports.
        if (frame_start) begin
          state_d   = ACTIVE;
          clear_trk = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fg    = pixel_valid & pre_img_Bit & (state_q == ACTIVE);
  assign found = (pix_cnt >= PIX_CNT_W'(MIN_PIXELS));

  always_ff @(posedge clk) begin
    if (rst || clear_trk) begin
      x_min   <= '1;
      x_max   <= '0;
      y_min   <= '1;
      y_max   <= '0;
      pix_cnt <= '0;
    end else if (fg) begin
      if (x < x_min) x_min <= x;
      if (x > x_max) x_max <= x;
      if (y < y_min) y_min <= y;
      if (y > y_max) y_max <= y;
      pix_cnt <= PIX_CNT_W'(sat_inc(32'(pix_cnt), PIX_CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bbox_valid <= 1'b0;
      bbox_found <= 1'b0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
    end else begin
      bbox_valid <= report;
      if (report) begin
        bbox_found <= found;
        bbox_x_min <= found ? x_min : '0;
        bbox_x_max <= found ? x_max : '0;
        bbox_y_min <= found ? y_min : '0;
        bbox_y_max <= found ? y_max : '0;
      end
    end
  end

`ifdef BBOX_PIX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         bbox_pix_cnt <= '0;
    else if (report) bbox_pix_cnt <= pix_cnt;
  end
`else
  // Without the port the count only feeds the MIN_PIXELS threshold.
`endif

endmodule

// File: doc/binary_bbox_detector.md
# binary_bbox_detector

Consumes the 1-bit binary mask stream (vsync/href/clken/pixel) emitted by the morphology stages of the human-detection chain and reports, once per frame, the bounding box enclosing all foreground pixels. It is the stream reader at the end of the binary-mask path: upstream filters write the mask, and this block reduces it to coordinates for the overlay and stitching logic. Output is a one-cycle report pulse plus coordinates that are held until the next report.

## Interface
- H_CNT_W, 12, width of column counter and x outputs
- V_CNT_W, 12, width of row counter and y outputs
- MIN_PIXELS, 64, minimum foreground pixel count for a frame to report a box
- PIX_CNT_W, 24, width of foreground pixel counter
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pre_frame_vsync  in  1  high for the whole active frame
- pre_frame_href  in  1  high for each active line
- pre_frame_clken  in  1  pixel qualifier
- pre_img_Bit  in  1  mask pixel, 1 = foreground
- bbox_valid  out  1  one-cycle pulse per completed frame
- bbox_found  out  1  1 = frame had at least MIN_PIXELS foreground pixels
- bbox_x_min, bbox_x_max  out  H_CNT_W  column bounds (inclusive)
- bbox_y_min, bbox_y_max  out  V_CNT_W  row bounds (inclusive)
- bbox_pix_cnt  out  PIX_CNT_W  foreground count (only with BBOX_PIX_CNT_EN)

## Operation
- A pixel is processed on each clk edge that samples vsync, href and clken all high. x = index within the line; y = index of the line within the frame.
- x increments per processed pixel and clears on the href falling edge. y increments on each href falling edge that closes a line containing at least one processed pixel. Both counters saturate at all-ones and never wrap.
- FSM states:
  - IDLE: wait for a vsync rising edge (previous sample 0, current sample 1).
  - ACTIVE: accumulate. On a vsync falling edge, go to REPORT.
  - REPORT: lasts one cycle, then returns to IDLE. If a vsync rising edge is sampled during REPORT, go directly to ACTIVE.
- On entry to ACTIVE, clear the trackers: x_min/y_min to all-ones, x_max/y_max to 0, pixel count to 0, and both counters.
- Each foreground pixel updates all four min/max trackers and the count. The count saturates at all-ones.
- REPORT latches the outputs:
  - found = (count >= MIN_PIXELS).
  - If found, the coordinates are the tracked values. Otherwise all coordinates are 0.
- Outputs hold their values between reports.
- A frame already in progress when reset releases is ignored, because no rising edge is seen. Reset mid-frame discards the partial frame.
- A vsync falling edge in IDLE is ignored.

## Timing
- Reset values: every output 0, FSM in IDLE, all edge-detect history registers 0.
- Latency: bbox_valid is high for exactly one cycle, on the clk edge after the edge that first samples vsync low. The outputs change on that same edge.
- A pixel sampled in the same cycle as the vsync falling edge is not counted, because vsync is low.
- Back-to-back frames with one low-vsync cycle between them both report; the second frame's ACTIVE starts in the REPORT cycle.
- No backpressure. The consumer must capture on bbox_valid.

## Configuration
- BBOX_PIX_CNT_EN defined:
  - bbox_pix_cnt port is present.
  - It latches the saturated foreground count at REPORT, including when found = 0.
- Not defined:
  - Port and output register are absent.
  - The internal count is still present, because the MIN_PIXELS compare needs it.

## Structure
- Package bbox_pkg holds:
  - the FSM state enum (IDLE, ACTIVE, REPORT);
  - default width constants;
  - saturating-increment functions.
- Sub-module binary_stream_coord_counter generates the stream coordinates and edge events. It outputs x, y, pixel_valid, line_end, frame_start and frame_end, and contains the edge detectors and saturating counters. The top level holds the FSM, the trackers and the output latch.

## Test plan
All scenarios use H_CNT_W = V_CNT_W = 12 unless stated.
- Single blob: 16x8 frame, MIN_PIXELS = 4, foreground at columns 3..6 of rows 2..4 -> one pulse with found = 1 and box (3,6,2,4). With the macro, pix_cnt = 12.
- Below threshold: 3 isolated foreground pixels, MIN_PIXELS = 4 -> found = 0, all coordinates 0, pix_cnt = 3.
- Latency and hold: check that bbox_valid rises exactly 1 cycle after vsync is first sampled low and stays 1 cycle wide. Outputs are unchanged during the following frame until its report.
- Stalls: clken deasserted randomly inside lines, same blob as the single-blob test -> identical box. Empty lines (href with no clken) do not advance y.
- Mid-frame reset: rst asserted for 2 cycles during row 3 with vsync still high -> no pulse for that frame, outputs 0. The next full frame reports normally.
- Back-to-back frames with a 1-cycle vsync gap and different blobs -> two pulses, each with its own box, and no carry-over of trackers between frames.
